// File: rtl/audio_sample_fifo_if.sv
// Memory-mapped bus bundle between the CPU-side master and the sample FIFO.
interface audio_sample_fifo_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid,
    output iomem_wstrb,
    output iomem_addr,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  modport slave (
    input  iomem_valid,
    input  iomem_wstrb,
    input  iomem_addr,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Audio sample FIFO with a programmable sample-rate divider.
// The CPU pushes 12-bit samples over the iomem bus. Every sample period one sample is popped
// into sample_out, which feeds the PDM DAC.
module audio_sample_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  ADDR_HI   = 8'h04,
  parameter logic [15:0] DIV_RESET = 16'd1999
) (
  input  logic                clk,
  input  logic                reset,
  audio_sample_fifo_if.slave  bus,
  output logic [11:0]         sample_out,
  output logic                sample_strobe,
  output logic                irq_low
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [LvlW-1:0] LvlHalf = LvlW'(DEPTH / 2);

  logic            ready_q;
  logic [31:0]     rdata_q;
  logic [15:0]     div_q;
  logic [15:0]     cnt_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic [LvlW-1:0] level_d;
  logic            unr_q;
  logic            ovf_q;
  logic [11:0]     sample_q;
  logic            strobe_q;
  logic [11:0]     mem_q [DEPTH];

  logic        hit;
  logic        is_wr;
  logic [7:0]  off;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        tick;
  logic        empty;
  logic        full;
  logic        div_wr;
  logic        stat_clr;
  logic [15:0] div_d;
  logic [31:0] status_word;
  logic [31:0] rdata_d;

  // Respond only to an idle-bus request aimed at our address window.
  assign hit      = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == ADDR_HI);
  assign is_wr    = |bus.iomem_wstrb;
  assign off      = bus.iomem_addr[7:0];
  assign push     = hit && is_wr && (off == 8'h00) && (bus.iomem_wstrb[0] || bus.iomem_wstrb[1]);
  assign div_wr   = hit && is_wr && (off == 8'h08) && (|bus.iomem_wstrb[1:0]);
  assign stat_clr = hit && is_wr && (off == 8'h04) && bus.iomem_wstrb[3];

  assign tick    = (cnt_q == 16'd0);
  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlFull);
  assign pop     = tick && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign push_ok = push && (!full || pop);

  assign div_d = {bus.iomem_wstrb[1] ? bus.iomem_wdata[15:8] : div_q[15:8],
                  bus.iomem_wstrb[0] ? bus.iomem_wdata[7:0]  : div_q[7:0]};

  assign status_word = {6'd0, ovf_q, unr_q, 6'd0, full, empty, 7'd0, 9'(level_q)};

  // Level counter next state and read-data mux.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push_ok) begin
      level_d = level_q - LvlW'(1);
    end
    unique case (off)
      8'h04:   rdata_d = status_word;
      8'h08:   rdata_d = {16'd0, div_q};
      default: rdata_d = 32'd0;
    endcase
  end

  // Bus acknowledge: one-cycle ready, read data captured on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= hit;
      if (hit && !is_wr) begin
        rdata_q <= rdata_d;
      end
    end
  end

  // Sample-period divider, FIFO pointers/level, sticky flags and the output sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= DIV_RESET;
      cnt_q    <= DIV_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      unr_q    <= 1'b0;
      ovf_q    <= 1'b0;
      sample_q <= 12'h800;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= tick;
      // A divider write restarts the period so the next tick is a full period away.
      if (div_wr) begin
        div_q <= div_d;
        cnt_q <= div_d;
      end else if (tick) begin
        cnt_q <= div_q;
      end else begin
        cnt_q <= cnt_q - 16'd1;
      end
      if (pop) begin
        sample_q <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      level_q <= level_d;
      // Set wins over a same-cycle clear.
      unr_q <= (tick && empty) || (unr_q && !(stat_clr && bus.iomem_wdata[24]));
      ovf_q <= (push && !push_ok) || (ovf_q && !(stat_clr && bus.iomem_wdata[25]));
    end
  end

  // Sample storage; no reset needed since pointers and level define validity.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= bus.iomem_wdata[11:0];
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign sample_out      = sample_q;
  assign sample_strobe   = strobe_q;
  assign irq_low         = reset || (level_q <= LvlHalf);

  logic unused_bits;
  assign unused_bits = ^{bus.iomem_addr[23:8], bus.iomem_wdata[31:26], bus.iomem_wdata[23:16]};

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: bus driver tasks, a FIFO-content scoreboard and a strobe monitor.
module tb_audio_sample_fifo;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA = 32'h0400_0000;
  localparam logic [31:0] A_STAT = 32'h0400_0004;
  localparam logic [31:0] A_DIV  = 32'h0400_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] sample_out;
  logic        sample_strobe;
  logic        irq_low;

  audio_sample_fifo_if bus ();

  audio_sample_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_HI   (8'h04),
    .DIV_RESET (16'd1999)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .sample_out    (sample_out),
    .sample_strobe (sample_strobe),
    .irq_low       (irq_low)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = 0;
  int prev_strobe_cyc = 0;
  int unr_set_cyc = -1;

  logic [11:0] exp_q[$];
  logic [11:0] exp_sample = 12'h800;
  bit          exp_unr = 0;
  bit          exp_ovf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe either pops the oldest queued sample or holds (underrun).
  always @(posedge clk) begin
    #1;
    if (!reset && sample_strobe) begin
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
      strobe_cnt++;
      if (exp_q.size() > 0) begin
        exp_sample = exp_q.pop_front();
      end else begin
        exp_unr = 1;
        unr_set_cyc = cyc;
      end
      n_vec++;
      if (sample_out !== exp_sample) begin
        n_err++;
        $display("FAIL sample_on_strobe: got %h expected %h at cycle %0d",
                 sample_out, exp_sample, cyc);
      end
    end
  end

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(exp_q.size());
    s[16] = (exp_q.size() == 0);
    s[17] = (exp_q.size() == DEPTH);
    s[24] = exp_unr;
    s[25] = exp_ovf;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.iomem_valid = 1'b0;
    exp_q.delete();
    exp_sample = 12'h800;
    exp_unr = 0;
    exp_ovf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic bus_xfer(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd,
                          input bit exp_ack, output logic [31:0] rd);
    bit acked;
    acked = 0;
    rd = 32'hx;
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_wstrb = strb;
    bus.iomem_addr  = addr;
    bus.iomem_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      if (bus.iomem_ready === 1'b1) begin
        acked = 1;
        rd = bus.iomem_rdata;
        break;
      end
    end
    bus.iomem_valid = 1'b0;
    n_vec++;
    if (acked != exp_ack) begin
      n_err++;
      $display("FAIL bus_ack addr=%h: got ack %0d expected %0d", addr, acked, exp_ack);
    end
    if (acked && strb != 4'd0) begin
      if (addr[7:0] == 8'h00 && (strb[0] || strb[1])) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(wd[11:0]);
        else exp_ovf = 1;
      end
      if (addr[7:0] == 8'h04 && strb[3]) begin
        if (wd[24] && unr_set_cyc != cyc) exp_unr = 0;
        if (wd[25]) exp_ovf = 0;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    n_vec++; if (bus.iomem_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", bus.iomem_ready); end
    n_vec++; if (bus.iomem_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h expected 0", bus.iomem_rdata); end
    n_vec++; if (sample_out !== 12'h800) begin n_err++; $display("FAIL rst_sample: got %h expected 800", sample_out); end
    n_vec++; if (sample_strobe !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b expected 0", sample_strobe); end
    n_vec++; if (irq_low !== 1'b1) begin n_err++; $display("FAIL rst_irq_low: got %b expected 1", irq_low); end
    // Ready must rise exactly one cycle after valid and last one cycle.
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_wstrb = 4'd0;
    bus.iomem_addr  = A_STAT;
    n_vec++; if (bus.iomem_ready !== 1'b0) begin n_err++; $display("FAIL ready_early: got %b expected 0", bus.iomem_ready); end
    @(posedge clk); #2;
    n_vec++; if (bus.iomem_ready !== 1'b1) begin n_err++; $display("FAIL ready_one_cycle: got %b expected 1", bus.iomem_ready); end
    n_vec++; if (bus.iomem_rdata !== 32'h0001_0000) begin n_err++; $display("FAIL status_empty: got %h expected 00010000", bus.iomem_rdata); end
    bus.iomem_valid = 1'b0;
    @(posedge clk); #2;
    n_vec++; if (bus.iomem_ready !== 1'b0) begin n_err++; $display("FAIL ready_drop: got %b expected 0", bus.iomem_ready); end
    bus_xfer(4'd0, A_DIV, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'd1999) begin n_err++; $display("FAIL div_reset: got %0d expected 1999", rd); end
    bus_xfer(4'd0, A_DATA, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL data_read: got %h expected 0", rd); end
    bus_xfer(4'd0, 32'h0500_0004, 32'd0, 0, rd);
    bus_xfer(4'hF, 32'h0400_0010, 32'hFFFF_FFFF, 1, rd);
    bus_xfer(4'd0, 32'h0400_0010, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL unmapped_read: got %h expected 0", rd); end
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (strobe_cnt >= target) break;
      @(posedge clk); #3;
    end
    n_vec++;
    if (strobe_cnt < target) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d strobes expected %0d", name, strobe_cnt, target);
    end
  endtask

  task automatic test_divider();
    logic [31:0] rd;
    int base;
    do_reset();
    base = strobe_cnt;
    bus_xfer(4'b0011, A_DIV, 32'd3, 1, rd);
    bus_xfer(4'b0001, A_DATA, 32'h123, 1, rd);
    bus_xfer(4'b0010, A_DATA, 32'h456, 1, rd);
    wait_strobes(base + 2, 40, "divider");
    n_vec++; if (last_strobe_cyc - prev_strobe_cyc != 4) begin n_err++; $display("FAIL tick_spacing: got %0d expected 4", last_strobe_cyc - prev_strobe_cyc); end
    n_vec++; if (sample_out !== 12'h456) begin n_err++; $display("FAIL second_sample: got %h expected 456", sample_out); end
    bus_xfer(4'd0, A_DIV, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'd3) begin n_err++; $display("FAIL div_readback: got %h expected 3", rd); end
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
  endtask

  task automatic test_overflow_underrun();
    logic [31:0] rd;
    int base;
    do_reset();
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
    for (int i = 0; i < 17; i++) begin
      bus_xfer(4'b0001, A_DATA, 32'h100 + 32'(i), 1, rd);
      if (i == 7) begin
        n_vec++; if (irq_low !== 1'b1) begin n_err++; $display("FAIL irq_at_half: got %b expected 1", irq_low); end
      end
      if (i == 8) begin
        n_vec++; if (irq_low !== 1'b0) begin n_err++; $display("FAIL irq_above_half: got %b expected 0", irq_low); end
      end
    end
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'h0202_0010) begin n_err++; $display("FAIL status_full_ovf: got %h expected 02020010", rd); end
    n_vec++; if (rd !== exp_status()) begin n_err++; $display("FAIL status_model_full: got %h expected %h", rd, exp_status()); end
    base = strobe_cnt;
    bus_xfer(4'b0011, A_DIV, 32'd1, 1, rd);
    wait_strobes(base + 17, 100, "drain");
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
    n_vec++; if (sample_out !== 12'h10F) begin n_err++; $display("FAIL held_sample: got %h expected 10f", sample_out); end
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'h0301_0000) begin n_err++; $display("FAIL status_underrun: got %h expected 03010000", rd); end
    bus_xfer(4'b1000, A_STAT, 32'h0100_0000, 1, rd);
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'h0201_0000) begin n_err++; $display("FAIL clear_underrun: got %h expected 02010000", rd); end
    bus_xfer(4'b1000, A_STAT, 32'h0200_0000, 1, rd);
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== exp_status() || rd !== 32'h0001_0000) begin n_err++; $display("FAIL clear_overflow: got %h expected 00010000", rd); end
  endtask

  task automatic test_push_on_tick();
    logic [31:0] rd;
    int base;
    do_reset();
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
    for (int i = 0; i < 16; i++) bus_xfer(4'b0001, A_DATA, 32'h200 + 32'(i), 1, rd);
    // Divider 3 puts the tick four edges after this write, i.e. on the second access after it.
    bus_xfer(4'b0011, A_DIV, 32'd3, 1, rd);
    bus_xfer(4'd0, 32'h0400_000C, 32'd0, 1, rd);
    bus_xfer(4'b0001, A_DATA, 32'hABC, 1, rd);
    n_vec++; if (sample_strobe !== 1'b1) begin n_err++; $display("FAIL push_tick_align: got strobe %b expected 1", sample_strobe); end
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'h0002_0010) begin n_err++; $display("FAIL full_push_pop: got %h expected 00020010", rd); end
    n_vec++; if (rd !== exp_status()) begin n_err++; $display("FAIL status_model_tick: got %h expected %h", rd, exp_status()); end
    base = strobe_cnt;
    bus_xfer(4'b0011, A_DIV, 32'd0, 1, rd);
    wait_strobes(base + 16, 40, "drain_fast");
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
    n_vec++; if (sample_out !== 12'hABC) begin n_err++; $display("FAIL last_pushed: got %h expected abc", sample_out); end
  endtask

  task automatic test_reset_midqueue();
    logic [31:0] rd;
    do_reset();
    bus_xfer(4'b0011, A_DIV, 32'hFFFF, 1, rd);
    for (int i = 0; i < 5; i++) bus_xfer(4'b0001, A_DATA, 32'h011 + 32'(i), 1, rd);
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL level_five: got %h expected 00000005", rd); end
    @(negedge clk);
    reset = 1'b1;
    bus.iomem_valid = 1'b1;
    bus.iomem_wstrb = 4'd0;
    bus.iomem_addr  = A_STAT;
    exp_q.delete();
    exp_sample = 12'h800;
    exp_unr = 0;
    exp_ovf = 0;
    @(posedge clk); #2;
    n_vec++; if (bus.iomem_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b expected 0", bus.iomem_ready); end
    n_vec++; if (sample_out !== 12'h800) begin n_err++; $display("FAIL abort_sample: got %h expected 800", sample_out); end
    n_vec++; if (irq_low !== 1'b1) begin n_err++; $display("FAIL abort_irq: got %b expected 1", irq_low); end
    @(posedge clk); #2;
    n_vec++; if (bus.iomem_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready2: got %b expected 0", bus.iomem_ready); end
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    reset = 1'b0;
    bus_xfer(4'd0, A_STAT, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'h0001_0000) begin n_err++; $display("FAIL post_reset_status: got %h expected 00010000", rd); end
    bus_xfer(4'd0, A_DIV, 32'd0, 1, rd);
    n_vec++; if (rd !== 32'd1999) begin n_err++; $display("FAIL post_reset_div: got %0d expected 1999", rd); end
  endtask

  initial begin
    reset = 1'b1;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'd0;
    bus.iomem_addr  = 32'd0;
    bus.iomem_wdata = 32'd0;
    test_reset();
    test_divider();
    test_overflow_underrun();
    test_push_on_tick();
    test_reset_midqueue();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the FIFO depth in 12-bit samples; legal values are powers of two from 4 to 256.
REQ-002 SHALL have parameter ADDR_HI, default 8'h04, meaning the iomem_addr[31:24] decode value.
REQ-003 SHALL have parameter DIV_RESET, default 16'd1999, meaning the reset value of the divider register (16 MHz / 2000 = 8 kHz).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port iomem_valid, input, 1 bit: bus request.
REQ-007 SHALL have port iomem_ready, output, 1 bit: one-cycle acknowledge.
REQ-008 SHALL have port iomem_wstrb, input, 4 bits: byte write strobes; the value 0 means a read.
REQ-009 SHALL have port iomem_addr, input, 32 bits: byte address.
REQ-010 SHALL have port iomem_wdata, input, 32 bits: write data.
REQ-011 SHALL have port iomem_rdata, output, 32 bits: read data, valid while iomem_ready=1.
REQ-012 SHALL have port sample_out, output, 12 bits: current sample, fed to the PDM DAC din.
REQ-013 SHALL have port sample_strobe, output, 1 bit: one-cycle pulse on every sample period tick.
REQ-014 SHALL have port irq_low, output, 1 bit: level signal, high while FIFO level <= DEPTH/2.

Function
REQ-015 Block SHALL respond only when iomem_valid=1, iomem_ready=0 and iomem_addr[31:24]==ADDR_HI.
REQ-016 On a responding access, iomem_ready SHALL be asserted in the following cycle for exactly one cycle; it SHALL be 0 otherwise.
REQ-017 On a responding read, iomem_rdata SHALL be loaded in the same edge that sets iomem_ready; on a non-responding access it SHALL hold its last value.
REQ-018 Register map uses addr[7:0]; unmapped offsets SHALL ack, read 0 and ignore writes.
REQ-019 Offset 0x00 DATA: a write with wstrb[0] or wstrb[1] set SHALL push wdata[11:0] once; a read SHALL return 0.
REQ-020 Offset 0x04 STATUS read format: bits[8:0] level (0..DEPTH), bit16 empty, bit17 full, bit24 underrun sticky, bit25 overflow sticky; all other bits 0.
REQ-021 A STATUS write with wstrb[3] set SHALL clear bit24 where wdata[24]=1 and bit25 where wdata[25]=1.
REQ-022 Offset 0x08 DIVIDER: R/W 16 bits in wdata[15:0] under wstrb[1:0]; the sample period SHALL be DIVIDER+1 clocks; reads SHALL zero-extend.
REQ-023 A down-counter SHALL reload to DIVIDER on a tick and otherwise decrement; a tick SHALL occur in the cycle the counter equals 0.
REQ-024 A DIVIDER write SHALL also reload the counter to the new value, so the next tick follows DIVIDER+1 clocks later.
REQ-025 On a tick with the FIFO not empty, the block SHALL pop the head; sample_out SHALL show the popped sample from the next cycle and hold it until the next pop.
REQ-026 On a tick with the FIFO empty, sample_out SHALL hold its value and underrun SHALL be set.
REQ-027 sample_strobe SHALL pulse in the cycle after every tick, aligned with the sample_out update.
REQ-028 A push while full SHALL be accepted if a pop occurs in the same cycle; otherwise it SHALL be dropped and overflow set.
REQ-029 A push and a tick in the same cycle with the FIFO empty SHALL cause underrun, and the pushed sample SHALL be stored.
REQ-030 Simultaneous push and pop SHALL leave the level unchanged.
REQ-031 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; level SHALL be a separate counter.
REQ-032 The sticky-set condition SHALL take priority over a same-cycle clear.

Reset
REQ-033 Reset SHALL, at the clock edge: empty the FIFO (level 0, pointers 0), clear both stickies, load DIVIDER=DIV_RESET and counter=DIV_RESET, and drive iomem_ready=0, iomem_rdata=0, sample_out=12'h800 (midscale), sample_strobe=0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no ack; irq_low SHALL be 1 during and after reset (level 0).

Verification
REQ-035 Bench SHALL cover: reset, then STATUS read -> rdata=32'h0001_0000 (empty), ready exactly one cycle after valid.
REQ-036 Bench SHALL cover: DIVIDER=3, push 0x123, 0x456 -> sample_out=0x123 then 0x456 at 4-clock spacing, with a strobe each tick.
REQ-037 Bench SHALL cover: DEPTH=16, 17 pushes with no ticks -> level=16, full=1, overflow=1, the 17th sample absent.
REQ-038 Bench SHALL cover: FIFO drained, a further tick -> sample_out held, underrun=1; STATUS write 32'h0100_0000 -> underrun=0.
REQ-039 Bench SHALL cover: full FIFO with push on the tick cycle -> push accepted, level stays 16, overflow stays 0.
REQ-040 Bench SHALL cover: reset asserted with 5 samples queued -> level=0, sample_out=0x800, DIVIDER=1999.
